// File: rtl/win_mul_rr_sched.sv
// -----------------------------------------------------------------------------
// win_mul_rr_sched
//
// Time-shares one 8x8 unsigned shift-add multiplier among NUM_REQ requesters.
// A work-conserving round-robin arbiter picks one valid requester per cycle.
// The product is returned on a single result bus, tagged with the index of the
// requester that issued it. A wrapping counter tracks consumed results.
//
// Optional feature (macro WIN_MUL_PIPE_REG_EN):
//   defined   - an operand register stage (a, b, id, valid) sits in front of
//               the multiplier, so latency is two edges.
//   undefined - the granted operands feed the multiplier directly and the
//               product is captured in the output register one edge after
//               accept.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]    per-requester operand valid
//   req_ready  out  [NUM_REQ]    per-requester accept, one-hot or zero
//   req_a      in   [NUM_REQ*8]  packed multiplicands, requester i at [8i+7:8i]
//   req_b      in   [NUM_REQ*8]  packed multipliers, same packing
//   res_valid  out  result valid
//   res_ready  in   result consumer ready
//   res_data   out  [16]         unsigned product a*b
//   res_id     out  [ID_W]       index of the issuing requester
//   op_cnt     out  [CNT_W]      number of consumed results, wraps
// -----------------------------------------------------------------------------
module win_mul_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_data,
  output logic [ID_W-1:0]      res_id,
  output logic [CNT_W-1:0]     op_cnt
);

  // Unsigned 8x8 multiply as the sum of eight shifted partial products.
  function automatic logic [15:0] shift_add_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'd0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        acc = acc + ({8'd0, a} << k);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  logic [ID_W-1:0]    rr_ptr_r;
  logic               res_valid_r;
  logic [15:0]        res_data_r;
  logic [ID_W-1:0]    res_id_r;
  logic [CNT_W-1:0]   op_cnt_r;

  logic               out_load_s;
  logic               front_ready_s;
  logic               found_s;
  int                 idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [7:0]         grant_a_s;
  logic [7:0]         grant_b_s;

  logic               mul_valid_s;
  logic [7:0]         mul_a_s;
  logic [7:0]         mul_b_s;
  logic [ID_W-1:0]    mul_id_s;
  logic [15:0]        product_s;

  // The output register can take a new value when empty or being drained.
  assign out_load_s = !res_valid_r || res_ready;

  // Round-robin search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    grant_a_s   = 8'd0;
    grant_b_s   = 8'd0;
    found_s     = 1'b0;
    idx_s       = 0;
    if (front_ready_s) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_s = int'(rr_ptr_r) + k;
        if (idx_s >= NUM_REQ) begin
          idx_s = idx_s - NUM_REQ;
        end else begin
          idx_s = idx_s;
        end
        if (!found_s && req_valid[idx_s]) begin
          found_s        = 1'b1;
          grant_s[idx_s] = 1'b1;
          grant_idx_s    = ID_W'(idx_s);
          grant_a_s      = req_a[idx_s*8 +: 8];
          grant_b_s      = req_b[idx_s*8 +: 8];
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  assign req_ready = grant_s;

  // Pointer moves just past the winner on an accept and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (found_s) begin
      if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= grant_idx_s + ID_W'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

`ifdef WIN_MUL_PIPE_REG_EN
  logic            op_valid_r;
  logic [7:0]      op_a_r;
  logic [7:0]      op_b_r;
  logic [ID_W-1:0] op_id_r;

  // The operand stage can refill when empty or when its content moves on.
  assign front_ready_s = !op_valid_r || out_load_s;

  // Operand stage: captures the granted operands ahead of the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_r <= 1'b0;
      op_a_r     <= 8'd0;
      op_b_r     <= 8'd0;
      op_id_r    <= '0;
    end else if (front_ready_s) begin
      op_valid_r <= found_s;
      if (found_s) begin
        op_a_r  <= grant_a_s;
        op_b_r  <= grant_b_s;
        op_id_r <= grant_idx_s;
      end
    end
  end

  assign mul_valid_s = op_valid_r;
  assign mul_a_s     = op_a_r;
  assign mul_b_s     = op_b_r;
  assign mul_id_s    = op_id_r;
`else
  assign front_ready_s = out_load_s;
  assign mul_valid_s   = found_s;
  assign mul_a_s       = grant_a_s;
  assign mul_b_s       = grant_b_s;
  assign mul_id_s      = grant_idx_s;
`endif

  assign product_s = shift_add_mul(mul_a_s, mul_b_s);

  // Output register: holds under backpressure, otherwise takes the next product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= 16'd0;
      res_id_r    <= '0;
    end else if (out_load_s) begin
      res_valid_r <= mul_valid_s;
      if (mul_valid_s) begin
        res_data_r <= product_s;
        res_id_r   <= mul_id_s;
      end
    end
  end

  // Consumed-result counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_r <= '0;
    end else if (res_valid_r && res_ready) begin
      op_cnt_r <= op_cnt_r + CNT_W'(1);
    end else begin
      op_cnt_r <= op_cnt_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign op_cnt    = op_cnt_r;

endmodule
